// File: rtl/common.sv
// Shared types for the graphics datapath.
package common;

    // Rasterizer command codes.
    typedef enum logic [1:0] {
        RASTER_CMD_FILL  = 2'd0,
        RASTER_CMD_POINT = 2'd1,
        RASTER_CMD_LINE  = 2'd2,
        RASTER_CMD_RECT  = 2'd3
    } raster_command_t;

endpackage

// File: rtl/gpu_rasterizer_if.sv
// Command and framebuffer-write bundle between a command source and the rasterizer.
interface gpu_rasterizer_if;
    import common::*;

    raster_command_t gpu_command;
    logic [7:0]      gpu_x0;
    logic [7:0]      gpu_y0;
    logic [7:0]      gpu_x1;
    logic [7:0]      gpu_y1;
    logic [2:0]      gpu_colour;
    logic            gpu_execute_request;
    logic            gpu_busy;
    logic [15:0]     fb_addr;
    logic [2:0]      fb_wdata;
    logic            fb_we;

    modport master (
        output gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour,
               gpu_execute_request,
        input  gpu_busy, fb_addr, fb_wdata, fb_we
    );

    modport slave (
        input  gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour,
               gpu_execute_request,
        output gpu_busy, fb_addr, fb_wdata, fb_we
    );

endinterface

// File: rtl/gpu_rasterizer.sv
// Pixel rasterizer: fill, point, filled rectangle and Bresenham line.
// One pixel is presented per busy cycle; off-screen pixels still take a cycle
// but are not written.
module gpu_rasterizer #(
    parameter int FB_WIDTH  = 214,
    parameter int FB_HEIGHT = 160
) (
    input logic             clk,
    input logic             rst_async,
    gpu_rasterizer_if.slave bus
);
    import common::*;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FILL  = 3'd1;
    localparam logic [2:0] POINT = 3'd2;
    localparam logic [2:0] RECT  = 3'd3;
    localparam logic [2:0] LINE  = 3'd4;

    localparam logic [7:0]  LAST_X = 8'(FB_WIDTH - 1);
    localparam logic [7:0]  LAST_Y = 8'(FB_HEIGHT - 1);
    localparam logic [15:0] WIDTH16  = 16'(FB_WIDTH);
    localparam logic [15:0] HEIGHT16 = 16'(FB_HEIGHT);

    logic [2:0]         state;
    logic [7:0]         op_x0, op_y0, op_x1, op_y1;
    logic [2:0]         op_colour;
    logic [7:0]         cur_x, cur_y;
    logic signed [11:0] err;

    logic [7:0]         x_min, x_max, y_max, dx_abs, dy_abs;
    logic [7:0]         in_x_min, in_y_min, in_dx, in_dy;
    logic               sx_neg, sy_neg;
    logic signed [11:0] dx_s, dy_s, e2, err_next;
    logic               step_x, step_y;
    logic               busy, in_bounds, last_pixel;
    logic [15:0]        pix_addr;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a <= b) ? a : b;
    endfunction

    // Geometry derived from the registered operands, plus the Bresenham step decision.
    always_comb begin
        x_min    = min8(op_x0, op_x1);
        x_max    = (op_x0 >= op_x1) ? op_x0 : op_x1;
        y_max    = (op_y0 >= op_y1) ? op_y0 : op_y1;
        dx_abs   = abs_diff(op_x1, op_x0);
        dy_abs   = abs_diff(op_y1, op_y0);
        sx_neg   = op_x1 < op_x0;
        sy_neg   = op_y1 < op_y0;
        dx_s     = $signed({4'b0, dx_abs});
        dy_s     = -$signed({4'b0, dy_abs});
        e2       = err <<< 1;
        step_x   = e2 >= dy_s;
        step_y   = e2 <= dx_s;
        err_next = err + (step_x ? dy_s : 12'sd0) + (step_y ? dx_s : 12'sd0);
        in_x_min = min8(bus.gpu_x0, bus.gpu_x1);
        in_y_min = min8(bus.gpu_y0, bus.gpu_y1);
        in_dx    = abs_diff(bus.gpu_x1, bus.gpu_x0);
        in_dy    = abs_diff(bus.gpu_y1, bus.gpu_y0);
    end

    // Decide whether the pixel on the bus this cycle is the command's final one.
    always_comb begin
        last_pixel = 1'b1;
        case (state)
            FILL:    last_pixel = (cur_x == LAST_X) && (cur_y == LAST_Y);
            RECT:    last_pixel = (cur_x == x_max) && (cur_y == y_max);
            LINE:    last_pixel = (cur_x == op_x1) && (cur_y == op_y1);
            default: last_pixel = 1'b1;
        endcase
    end

    assign busy      = (state != IDLE);
    assign pix_addr  = 16'(cur_y) * WIDTH16 + 16'(cur_x);
    assign in_bounds = (16'(cur_x) < WIDTH16) && (16'(cur_y) < HEIGHT16);

    assign bus.gpu_busy = busy;
    assign bus.fb_we    = busy && in_bounds;
    assign bus.fb_addr  = busy ? pix_addr : 16'd0;
    assign bus.fb_wdata = busy ? op_colour : 3'd0;

    // Command acceptance in IDLE and per-cycle pixel stepping while busy.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state     <= IDLE;
            op_x0     <= '0;
            op_y0     <= '0;
            op_x1     <= '0;
            op_y1     <= '0;
            op_colour <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            err       <= '0;
        end else if (state == IDLE) begin
            if (bus.gpu_execute_request) begin
                op_x0     <= bus.gpu_x0;
                op_y0     <= bus.gpu_y0;
                op_x1     <= bus.gpu_x1;
                op_y1     <= bus.gpu_y1;
                op_colour <= bus.gpu_colour;
                err       <= $signed({4'b0, in_dx}) - $signed({4'b0, in_dy});
                case (bus.gpu_command)
                    RASTER_CMD_FILL: begin
                        cur_x <= '0;
                        cur_y <= '0;
                        state <= FILL;
                    end
                    RASTER_CMD_POINT: begin
                        cur_x <= bus.gpu_x0;
                        cur_y <= bus.gpu_y0;
                        state <= POINT;
                    end
                    RASTER_CMD_RECT: begin
                        cur_x <= in_x_min;
                        cur_y <= in_y_min;
                        state <= RECT;
                    end
                    default: begin
                        cur_x <= bus.gpu_x0;
                        cur_y <= bus.gpu_y0;
                        state <= LINE;
                    end
                endcase
            end
        end else if (last_pixel) begin
            state <= IDLE;
        end else begin
            case (state)
                FILL: begin
                    if (cur_x == LAST_X) begin
                        cur_x <= '0;
                        cur_y <= cur_y + 8'd1;
                    end else begin
                        cur_x <= cur_x + 8'd1;
                    end
                end
                RECT: begin
                    if (cur_x == x_max) begin
                        cur_x <= x_min;
                        cur_y <= cur_y + 8'd1;
                    end else begin
                        cur_x <= cur_x + 8'd1;
                    end
                end
                LINE: begin
                    if (step_x) cur_x <= sx_neg ? cur_x - 8'd1 : cur_x + 8'd1;
                    if (step_y) cur_y <= sy_neg ? cur_y - 8'd1 : cur_y + 8'd1;
                    err <= err_next;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gpu_rasterizer.md
GPU_RASTERIZER -- requirements
Module: gpu_rasterizer

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 214, meaning framebuffer pixels per row.
REQ-002 SHALL have parameter FB_HEIGHT, default 160, meaning framebuffer rows.
REQ-003 SHALL have port clk  input  1  the 50MHz clock; the block's only clock.
REQ-004 SHALL have port rst_async  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port gpu_command  input  raster_command_t  command code from package common: RASTER_CMD_FILL, RASTER_CMD_POINT, RASTER_CMD_LINE or RASTER_CMD_RECT.
REQ-006 SHALL have ports gpu_x0, gpu_y0, gpu_x1, gpu_y1  input  8 each  unsigned operand coordinates.
REQ-007 SHALL have port gpu_colour  input  3  pixel colour.
REQ-008 SHALL have port gpu_execute_request  input  1  one-cycle start strobe.
REQ-009 SHALL have port gpu_busy  output  1  high while a command executes.
REQ-010 SHALL have ports fb_addr  output  16 (pixel index y*FB_WIDTH+x), fb_wdata  output  3 (colour) and fb_we  output  1 (write strobe).

Function
REQ-011 SHALL use states IDLE, FILL, POINT, RECT, LINE; gpu_busy = (state != IDLE).
REQ-012 In IDLE, a clock edge with gpu_execute_request=1 SHALL register command, all four coordinates and colour, then enter the command's state; gpu_busy is high from the next cycle.
REQ-013 gpu_execute_request while gpu_busy=1 SHALL be ignored; registered operands SHALL NOT change.
REQ-014 Each busy cycle SHALL present exactly one pixel on fb_addr/fb_wdata, with fb_we=1 unless clipped; fb_we=0 whenever gpu_busy=0.
REQ-015 Clipping: pixel with x>=FB_WIDTH or y>=FB_HEIGHT SHALL still take its cycle, with fb_we=0.
REQ-016 FILL: addresses 0..FB_WIDTH*FB_HEIGHT-1 ascending, one per cycle; 34240 busy cycles at defaults.
REQ-017 POINT: single pixel (x0,y0); 1 busy cycle.
REQ-018 RECT: filled, x from min(x0,x1) to max(x0,x1), y from min(y0,y1) to max(y0,y1), row-major (x fastest); (|x1-x0|+1)*(|y1-y0|+1) busy cycles.
REQ-019 LINE: integer Bresenham, all octants, both endpoints included: dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+-1 toward endpoint, err=dx+dy initially; per step e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy.
REQ-020 LINE SHALL take max(|dx|,|dy|)+1 busy cycles; err/e2 SHALL be signed and at least 10 bits wide, no overflow.
REQ-021 Degenerate LINE/RECT (x0=x1 and y0=y1) SHALL behave as POINT (1 cycle).
REQ-022 gpu_busy SHALL fall at the edge ending the last pixel cycle; a request in the first cycle with gpu_busy=0 SHALL be accepted (back-to-back commands).
REQ-023 fb_addr SHALL be computed exactly as y*FB_WIDTH+x in 16 bits; no wrap for in-bounds pixels.

Reset
REQ-024 rst_async=1 SHALL immediately force state IDLE, gpu_busy=0, fb_we=0, fb_addr=0, fb_wdata=0 and clear all operand/coordinate registers.
REQ-025 Reset mid-command SHALL abort it; no further fb_we pulse from that command after reset release.
REQ-026 After reset release the first request SHALL be accepted normally.

Verification
REQ-027 POINT (100,100) colour 6 -> one write, fb_addr=21500, fb_wdata=6; gpu_busy high exactly 1 cycle.
REQ-028 FILL colour 5 -> 34240 consecutive writes, addr 0..34239, data 5; gpu_busy high 34240 cycles.
REQ-029 LINE (10,10)->(100,100) colour 6 -> 91 writes, i-th addr (10+i)*214+(10+i); LINE (100,10)->(10,20) -> 91 writes, first addr 2240, last addr 4290.
REQ-030 RECT x0=204,y0=130,x1=10,y1=90 -> 7995 writes row-major, first addr 90*214+10=19270, last addr 130*214+204=28024.
REQ-031 POINT (220,5) -> gpu_busy 1 cycle, no fb_we; request pulsed mid-FILL -> ignored, FILL completes unchanged.
REQ-032 rst_async asserted mid-FILL -> gpu_busy=0 and fb_we=0 same cycle, no writes after release; next POINT executes correctly.
